// File: rtl/pht_predictor_pkg.sv
// Shared types and sizing for the PC/history-indexed pattern history table.
package pht_predictor_pkg;
  localparam int XLEN        = 32;
  localparam int PC_IDX_BITS = 5;
  localparam int HIST_BITS   = 3;
  localparam int PHT_IDX_W   = PC_IDX_BITS + HIST_BITS;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_INIT = 2'b01;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;
endpackage

// File: rtl/pht_sat2_next.sv
// Two-bit saturating counter step: move toward 3 on taken, toward 0 on not-taken.
module pht_sat2_next
  import pht_predictor_pkg::*;
(
  input  cnt_t i_cnt,
  input  logic i_taken,
  output cnt_t o_cnt
);
  always_comb begin
    o_cnt = i_cnt;
    if (i_taken && (i_cnt != 2'b11)) begin
      o_cnt = i_cnt + 2'd1;
    end else if (!i_taken && (i_cnt != 2'b00)) begin
      o_cnt = i_cnt - 2'd1;
    end
  end
endmodule

// File: rtl/pht_predictor.sv
// Gshare-style PHT without hashing: index = {pc[2 +: PC_IDX_BITS], hist}.
// The table is swept to CNT_INIT after reset; updates are registered one cycle before the write.
module pht_predictor #(
  parameter int         PC_IDX_BITS = pht_predictor_pkg::PC_IDX_BITS,
  parameter int         HIST_BITS   = pht_predictor_pkg::HIST_BITS,
  parameter logic [1:0] CNT_INIT    = pht_predictor_pkg::CNT_INIT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [pht_predictor_pkg::XLEN-1:0] if_pc,
  input  logic [HIST_BITS-1:0]               if_hist,
  input  logic                               ex_valid,
  input  logic [pht_predictor_pkg::XLEN-1:0] ex_pc,
  input  logic [HIST_BITS-1:0]               ex_hist,
  input  logic                               ex_taken,
  input  logic                               ex_pred_taken,
  output logic                               if_pred_taken,
  output logic                               ready,
  output logic [31:0]                        mispredict_count
);
  import pht_predictor_pkg::*;

  localparam int IDX_W = PC_IDX_BITS + HIST_BITS;
  localparam int DEPTH = 1 << IDX_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_init_ptr;
  logic [IDX_W-1:0] w_init_ptr_nxt;
  cnt_t             r_table [DEPTH];

  logic             r_upd_vld;
  logic [IDX_W-1:0] r_upd_idx;
  logic             r_upd_taken;
  logic [31:0]      r_mis_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_ready;
  logic             w_accept;
  cnt_t             w_cur_cnt;
  cnt_t             w_nxt_cnt;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  cnt_t             w_wdata;
  logic             w_unused_pc;

  assign w_if_idx    = {if_pc[2 +: PC_IDX_BITS], if_hist};
  assign w_ex_idx    = {ex_pc[2 +: PC_IDX_BITS], ex_hist};
  assign w_unused_pc = ^{if_pc[XLEN-1:2+PC_IDX_BITS], if_pc[1:0],
                         ex_pc[XLEN-1:2+PC_IDX_BITS], ex_pc[1:0]};

  // ready is also masked by reset so nothing leaks out during the reset cycle
  assign w_ready  = (r_state == ST_READY) && !reset;
  assign w_accept = ex_valid && w_ready;

  assign ready            = w_ready;
  assign if_pred_taken    = w_ready && r_table[w_if_idx][1];
  assign mispredict_count = r_mis_cnt;

  assign w_cur_cnt = r_table[r_upd_idx];

  pht_sat2_next u_sat (
    .i_cnt   (w_cur_cnt),
    .i_taken (r_upd_taken),
    .o_cnt   (w_nxt_cnt)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_we           = 1'b0;
    w_widx         = r_upd_idx;
    w_wdata        = w_nxt_cnt;
    case (r_state)
      ST_INIT: begin
        w_we           = !reset;
        w_widx         = r_init_ptr;
        w_wdata        = CNT_INIT;
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == {IDX_W{1'b1}}) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_we = r_upd_vld && !reset;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_upd_vld <= 1'b0;
      r_mis_cnt <= '0;
    end else begin
      r_upd_vld <= w_accept;
      if (w_accept && (ex_taken != ex_pred_taken) && (r_mis_cnt != 32'hFFFF_FFFF)) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

  // Update payload and table storage carry no reset; the INIT sweep owns table contents
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_upd_idx   <= w_ex_idx;
      r_upd_taken <= ex_taken;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_table[w_widx] <= w_wdata;
    end
  end
endmodule
